// File: rtl/pe_requant_collector.sv
// Collects the results of a bank of sequential dot-product PEs and requantizes them.
// Each element gets optional ReLU, a rounding shift and saturation, then the vector is handed off over valid/ready.
module pe_requant_collector #(
  parameter int NUM_PE    = 16,
  parameter int W         = 8,
  parameter int ACC_WIDTH = W + 7,
  parameter int SHIFT     = 4,
  parameter int RELU_EN   = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        go,
  output logic                        pe_start,
  input  logic [NUM_PE-1:0]           pe_done,
  input  logic [ACC_WIDTH*NUM_PE-1:0] pe_result_flat,
  output logic [W*NUM_PE-1:0]         out_vector_flat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic [$clog2(NUM_PE+1)-1:0] sat_count
);

  localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CW = $clog2(NUM_PE + 1);

  localparam logic signed [ACC_WIDTH:0] MAXV = (ACC_WIDTH+1)'((2 ** (W - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PROC,
    HOLD
  } state_t;

  state_t                        state;
  logic [IW-1:0]                 index;
  logic [ACC_WIDTH*NUM_PE-1:0]   cap_buf;

  logic signed [ACC_WIDTH-1:0]   x_raw;
  logic signed [ACC_WIDTH-1:0]   x_relu;
  logic signed [ACC_WIDTH:0]     x_ext;
  logic signed [ACC_WIDTH:0]     r_val;
  logic                          sat_hi;
  logic                          sat_lo;
  logic [W-1:0]                  y;

  always_comb begin
    x_raw  = cap_buf[index*ACC_WIDTH +: ACC_WIDTH];
    x_relu = ((RELU_EN != 0) && x_raw[ACC_WIDTH-1]) ? '0 : x_raw;
    x_ext  = {x_relu[ACC_WIDTH-1], x_relu};
  end

  // One extra bit of headroom keeps the rounding add from wrapping.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(2 ** (SHIFT - 1));
      assign r_val = (x_ext + RND) >>> SHIFT;
    end else begin : g_noround
      assign r_val = x_ext;
    end
  endgenerate

  always_comb begin
    sat_hi = (r_val > MAXV);
    sat_lo = (r_val < MINV);
    if (sat_hi)      y = MAXV[W-1:0];
    else if (sat_lo) y = MINV[W-1:0];
    else             y = r_val[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pe_start        <= 1'b0;
      out_valid       <= 1'b0;
      busy            <= 1'b0;
      out_vector_flat <= '0;
      sat_count       <= '0;
      index           <= '0;
      cap_buf         <= '0;
    end else begin
      pe_start <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            pe_start <= 1'b1;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // pe_done is stale while pe_start is still high.
          if (!pe_start && (&pe_done)) begin
            cap_buf   <= pe_result_flat;
            sat_count <= '0;
            index     <= '0;
            state     <= PROC;
          end
        end
        PROC: begin
          out_vector_flat[index*W +: W] <= y;
          if (sat_hi || sat_lo) sat_count <= sat_count + CW'(1);
          if (index == IW'(NUM_PE - 1)) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            index <= index + IW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_requant_collector.sv
// Directed bench for pe_requant_collector: a ReLU instance and a signed (RELU_EN=0) instance share stimulus.
module tb_pe_requant_collector;

  localparam int NUM_PE = 4;
  localparam int W      = 8;
  localparam int AW     = 15;
  localparam int SHIFT  = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 go;
  logic                 out_ready;
  logic [NUM_PE-1:0]    pe_done;
  logic [AW*NUM_PE-1:0] pe_result_flat;

  logic                 pe_start_r, out_valid_r, busy_r;
  logic [W*NUM_PE-1:0]  out_vec_r;
  logic [2:0]           sat_r;
  logic                 pe_start_s, out_valid_s, busy_s;
  logic [W*NUM_PE-1:0]  out_vec_s;
  logic [2:0]           sat_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_requant_collector #(.NUM_PE(NUM_PE), .W(W), .ACC_WIDTH(AW), .SHIFT(SHIFT), .RELU_EN(1)) u_relu (
    .clk(clk), .reset_n(reset_n), .go(go), .pe_start(pe_start_r), .pe_done(pe_done),
    .pe_result_flat(pe_result_flat), .out_vector_flat(out_vec_r), .out_valid(out_valid_r),
    .out_ready(out_ready), .busy(busy_r), .sat_count(sat_r));

  pe_requant_collector #(.NUM_PE(NUM_PE), .W(W), .ACC_WIDTH(AW), .SHIFT(SHIFT), .RELU_EN(0)) u_sgn (
    .clk(clk), .reset_n(reset_n), .go(go), .pe_start(pe_start_s), .pe_done(pe_done),
    .pe_result_flat(pe_result_flat), .out_vector_flat(out_vec_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .busy(busy_s), .sat_count(sat_s));

  function automatic logic [AW*NUM_PE-1:0] pack(input int a, input int b, input int c, input int d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  function automatic logic [W*NUM_PE-1:0] vec(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Launches one pass and plays the PEs: done bit i rises d_i cycles after the go edge.
  // Returns the cycle (counted from the go edge) at which out_valid was first seen.
  task automatic run_pass(input logic [AW*NUM_PE-1:0] res, input int d0, input int d1, input int d2,
                          input int d3, output int first_c, output logic ps0, output logic ps1,
                          output logic [W*NUM_PE-1:0] vr, output logic [W*NUM_PE-1:0] vs,
                          output logic [2:0] sr, output logic [2:0] ss);
    int dl[4];
    int dmax;
    dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
    dmax = d0;
    for (int i = 1; i < 4; i++) if (dl[i] > dmax) dmax = dl[i];
    pe_result_flat = res;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    ps0 = pe_start_r;
    ps1 = 1'b0;
    first_c = -1;
    vr = '0; vs = '0; sr = '0; ss = '0;
    for (int c = 1; c <= 60 && first_c < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        ps1 = pe_start_r;
        pe_done = '0;
      end
      for (int i = 0; i < 4; i++) if (c >= dl[i]) pe_done[i] = 1'b1;
      if (c == dmax + 2) pe_result_flat = ~res;
      if (out_valid_r) begin
        first_c = c;
        vr = out_vec_r; vs = out_vec_s; sr = sat_r; ss = sat_s;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid_r !== 1'b0 || busy_r !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake: valid=%b busy=%b required 0 0", out_valid_r, busy_r);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; go = 1'b0; out_ready = 1'b0; pe_done = '0; pe_result_flat = '0;
    #3 reset_n = 1'b0;
    #20;
    n_cmp++;
    if ({pe_start_r, out_valid_r, busy_r, out_vec_r, sat_r} !== '0 ||
        {pe_start_s, out_valid_s, busy_s, out_vec_s, sat_s} !== '0) begin
      n_bad++;
      $display("FAIL reset: relu=%h sgn=%h required 0",
               {pe_start_r, out_valid_r, busy_r, out_vec_r, sat_r},
               {pe_start_s, out_valid_s, busy_s, out_vec_s, sat_s});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int fc; logic p0, p1; logic [31:0] vr, vs; logic [2:0] sr, ss;
    pe_done = '1;
    run_pass(pack(100, -50, 2047, 8), 1, 1, 1, 1, fc, p0, p1, vr, vs, sr, ss);
    n_cmp++;
    if (fc !== 6) begin n_bad++; $display("FAIL basic_latency: got %0d required 6", fc); end
    n_cmp++;
    if (vr !== vec(6, 0, 127, 1)) begin n_bad++; $display("FAIL basic_vec: got %h required %h", vr, vec(6, 0, 127, 1)); end
    n_cmp++;
    if (sr !== 3'd1) begin n_bad++; $display("FAIL basic_sat: got %0d required 1", sr); end
    n_cmp++;
    if (vs !== vec(6, -3, 127, 1) || ss !== 3'd1) begin
      n_bad++; $display("FAIL basic_signed: got %h/%0d required %h/1", vs, ss, vec(6, -3, 127, 1));
    end
    handshake();
  endtask

  task automatic test_signed();
    int fc; logic p0, p1; logic [31:0] vr, vs; logic [2:0] sr, ss;
    run_pass(pack(-50, -16384, 16383, -8), 2, 2, 2, 2, fc, p0, p1, vr, vs, sr, ss);
    n_cmp++;
    if (fc !== 7) begin n_bad++; $display("FAIL signed_latency: got %0d required 7", fc); end
    n_cmp++;
    if (vs !== vec(-3, -128, 127, 0)) begin n_bad++; $display("FAIL signed_vec: got %h required %h", vs, vec(-3, -128, 127, 0)); end
    n_cmp++;
    if (ss !== 3'd2) begin n_bad++; $display("FAIL signed_sat: got %0d required 2", ss); end
    n_cmp++;
    if (vr !== vec(0, 0, 127, 0) || sr !== 3'd1) begin
      n_bad++; $display("FAIL signed_relu: got %h/%0d required %h/1", vr, sr, vec(0, 0, 127, 0));
    end
    handshake();
  endtask

  task automatic test_pe_handshake();
    int fc; logic p0, p1; logic [31:0] vr, vs; logic [2:0] sr, ss;
    pe_done = '1;
    run_pass(pack(100, -50, 2047, 8), 9, 3, 5, 6, fc, p0, p1, vr, vs, sr, ss);
    n_cmp++;
    if (p0 !== 1'b1 || p1 !== 1'b0) begin n_bad++; $display("FAIL pe_start_pulse: got %b%b required 10", p0, p1); end
    n_cmp++;
    if (fc !== 14) begin n_bad++; $display("FAIL capture_timing: got %0d required 14", fc); end
    n_cmp++;
    if (vr !== vec(6, 0, 127, 1) || sr !== 3'd1) begin
      n_bad++; $display("FAIL handshake_vec: got %h/%0d required %h/1", vr, sr, vec(6, 0, 127, 1));
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int fc; logic p0, p1; logic [31:0] vr, vs; logic [2:0] sr, ss;
    run_pass(pack(32, 47, -200, 1000), 1, 1, 1, 1, fc, p0, p1, vr, vs, sr, ss);
    n_cmp++;
    if (fc !== 6) begin n_bad++; $display("FAIL bp_latency: got %0d required 6", fc); end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) go = 1'b1;
      @(posedge clk); #1;
      if (k == 3) go = 1'b0;
      n_cmp++;
      if (out_valid_r !== 1'b1 || busy_r !== 1'b1 || out_vec_r !== vec(2, 3, 0, 63) || sat_r !== 3'd0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid=%b busy=%b vec=%h sat=%0d required 1 1 %h 0",
                 k, out_valid_r, busy_r, out_vec_r, sat_r, vec(2, 3, 0, 63));
      end
      if (k == 4) begin
        n_cmp++;
        if (pe_start_r !== 1'b0) begin n_bad++; $display("FAIL bp_go_ignored: pe_start=%b required 0", pe_start_r); end
      end
    end
    handshake();
  endtask

  task automatic test_reset_midop();
    int fc; logic p0, p1; logic [31:0] vr, vs; logic [2:0] sr, ss;
    pe_result_flat = pack(100, -50, 2047, 8);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) pe_done = '1;
    end
    n_cmp++;
    if (out_vec_r[7:0] !== 8'd6 || busy_r !== 1'b1) begin
      n_bad++; $display("FAIL midop_progress: slot0=%0d busy=%b required 6 1", out_vec_r[7:0], busy_r);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({pe_start_r, out_valid_r, busy_r, out_vec_r, sat_r} !== '0) begin
      n_bad++; $display("FAIL midop_reset: got %h required 0", {pe_start_r, out_valid_r, busy_r, out_vec_r, sat_r});
    end
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    run_pass(pack(100, -50, 2047, 8), 1, 1, 1, 1, fc, p0, p1, vr, vs, sr, ss);
    n_cmp++;
    if (fc !== 6 || vr !== vec(6, 0, 127, 1) || sr !== 3'd1) begin
      n_bad++; $display("FAIL midop_rerun: lat=%0d vec=%h sat=%0d required 6 %h 1", fc, vr, sr, vec(6, 0, 127, 1));
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int fc; logic p0, p1; logic [31:0] vr, vs; logic [2:0] sr, ss;
    out_ready = 1'b1;
    run_pass(pack(100, -50, 2047, 8), 1, 1, 1, 1, fc, p0, p1, vr, vs, sr, ss);
    n_cmp++;
    if (fc !== 6 || vr !== vec(6, 0, 127, 1) || sr !== 3'd1) begin
      n_bad++; $display("FAIL b2b_first: lat=%0d vec=%h sat=%0d required 6 %h 1", fc, vr, sr, vec(6, 0, 127, 1));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid_r !== 1'b0 || busy_r !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle: valid=%b busy=%b required 0 0", out_valid_r, busy_r);
    end
    run_pass(pack(32, 47, -200, 1000), 1, 1, 1, 1, fc, p0, p1, vr, vs, sr, ss);
    n_cmp++;
    if (p0 !== 1'b1 || fc !== 6) begin n_bad++; $display("FAIL b2b_launch: start=%b lat=%0d required 1 6", p0, fc); end
    n_cmp++;
    if (vr !== vec(2, 3, 0, 63) || sr !== 3'd0) begin
      n_bad++; $display("FAIL b2b_second: vec=%h sat=%0d required %h 0", vr, sr, vec(2, 3, 0, 63));
    end
    n_cmp++;
    if (vs !== vec(2, 3, -12, 63) || ss !== 3'd0) begin
      n_bad++; $display("FAIL b2b_signed: vec=%h sat=%0d required %h 0", vs, ss, vec(2, 3, -12, 63));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_pe_handshake();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
